receptor_serial_paridade: RTL and testbench

- Serial front end for the 5-bit + parity link, directly upstream of the parity verifier.
- Deserialises one frame from a single-wire line: start bit, b1..b5, bp, stop bit.
- Presents b1..b5 and bp in parallel, held stable, with a one-cycle valid strobe, so the verifier can compute S.
- Flags framing errors and does not judge parity itself.

---
 rtl/receptor_serial_paridade.sv | 158 +++++++++++++++
 tb/tb_receptor_serial_paridade.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/receptor_serial_paridade.sv
// Purpose: deserialises one start/b1..b5/bp/stop frame from a single-wire line and presents it in parallel.
// Latency: valid (or framing_err) pulses at edge t0 + CLKS_PER_BIT/2 + 7*CLKS_PER_BIT, where t0 is the start-bit detection edge.
// Backpressure: none; the line cannot be stalled, so the downstream verifier must accept each one-cycle strobe.
module receptor_serial_paridade #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic b1,
  output logic b2,
  output logic b3,
  output logic b4,
  output logic b5,
  output logic bp,
  output logic valid,
  output logic framing_err,
  output logic busy
);

  localparam int CW   = $clog2(CLKS_PER_BIT) + 1;
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [4:0]    shift_q, shift_d;   // b1 ends up in bit 0 after five right shifts
  logic          par_q, par_d;
  logic [5:0]    out_q, out_d;       // {bp, b5, b4, b3, b2, b1}; only loaded on a good stop bit
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          sample;

  // Next-state, sample-point and output-register logic for the frame walker.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    out_d   = out_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    sample  = 1'b0;

    // The start bit is re-checked mid-bit; every later bit is one full period after the previous sample.
    if (state_q == START) begin
      sample = (cnt_q == HALF_M1);
    end else if (state_q != IDLE && state_q != WAIT_IDLE) begin
      sample = (cnt_q == FULL_M1);
    end

    if (state_q != IDLE && state_q != WAIT_IDLE) begin
      cnt_d = sample ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx) begin
          state_d = START;
          idx_d   = 3'd0;
        end
      end
      START: begin
        if (sample) begin
          idx_d   = 3'd0;
          state_d = rx ? IDLE : DATA;
        end
      end
      DATA: begin
        if (sample) begin
          shift_d = {rx, shift_q[4:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd4) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (sample) begin
          par_d   = rx;
          idx_d   = idx_q + 3'd1;
          state_d = STOP;
        end
      end
      STOP: begin
        if (sample) begin
          idx_d = 3'd0;
          if (rx) begin
            out_d   = {par_q, shift_q};
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        // A held-low (break) line must not be mistaken for a new start bit.
        cnt_d = '0;
        if (rx) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counters and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 5'd0;
      par_q   <= 1'b0;
      out_q   <= 6'd0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign b1          = out_q[0];
  assign b2          = out_q[1];
  assign b3          = out_q[2];
  assign b4          = out_q[3];
  assign b5          = out_q[4];
  assign bp          = out_q[5];
  assign valid       = valid_q;
  assign framing_err = ferr_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_receptor_serial_paridade.sv
// Purpose: directed self-checking bench for receptor_serial_paridade with CLKS_PER_BIT=4.
// Latency: checks strobes at t0+29/30/31 of each frame and the false-start exit at t0+2.
// Backpressure: none; inputs driven and outputs sampled on the falling clock edge.
module tb_receptor_serial_paridade;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst;
  logic rx;
  logic b1, b2, b3, b4, b5, bp;
  logic valid, framing_err, busy;

  int n_assert = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_ferr   = 0;
  int n_both   = 0;

  receptor_serial_paridade #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .b1          (b1),
    .b2          (b2),
    .b3          (b3),
    .b4          (b4),
    .b5          (b5),
    .bp          (bp),
    .valid       (valid),
    .framing_err (framing_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Count strobe cycles independently of the directed checks.
  always @(negedge clk) begin
    if (valid === 1'b1) n_valid++;
    if (framing_err === 1'b1) n_ferr++;
    if (valid === 1'b1 && framing_err === 1'b1) n_both++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {bp, b5, b4, b3, b2, b1};
  endfunction

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  // Sends start, d[0]=b1..d[4]=b5, p, then the stop bit for one full period, checking strobes around t0+30.
  task automatic send_frame(input string tag, input logic [4:0] d, input logic p, input logic stop,
                            input logic [5:0] exp_out, input logic exp_good);
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(d[i]);
    send_bit(p);
    rx = stop;
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_valid_early"}, {31'd0, valid}, 32'd0);
    chk({tag, "_ferr_early"}, {31'd0, framing_err}, 32'd0);
    @(negedge clk);
    chk({tag, "_valid"}, {31'd0, valid}, {31'd0, exp_good});
    chk({tag, "_ferr"}, {31'd0, framing_err}, {31'd0, ~exp_good});
    chk({tag, "_outs"}, {26'd0, outs()}, {26'd0, exp_out});
    chk({tag, "_busy"}, {31'd0, busy}, {31'd0, ~exp_good});
    @(negedge clk);
    chk({tag, "_valid_late"}, {31'd0, valid}, 32'd0);
    chk({tag, "_ferr_late"}, {31'd0, framing_err}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outs", {26'd0, outs()}, 32'd0);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_ferr", {31'd0, framing_err}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    // Idle line: nothing happens for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_flags", {29'd0, valid, framing_err, busy}, 32'd0);
    end
    chk("idle_outs", {26'd0, outs()}, 32'd0);

    // Good frame b1..b5 = 1,0,1,1,0, bp = 1.
    send_frame("good1", 5'b01101, 1'b1, 1'b1, 6'b101101, 1'b1);
    repeat (5) @(negedge clk);
    chk("good1_hold", {26'd0, outs()}, {26'd0, 6'b101101});

    // Same frame with a low stop bit: outputs keep previous values, busy until line returns high.
    send_frame("ferr", 5'b01101, 1'b1, 1'b0, 6'b101101, 1'b0);
    repeat (6) @(negedge clk);
    chk("ferr_wait_busy", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    @(negedge clk);
    chk("ferr_idle_busy", {31'd0, busy}, 32'd0);
    chk("ferr_hold_outs", {26'd0, outs()}, {26'd0, 6'b101101});
    repeat (3) @(negedge clk);

    // False start: one low cycle, rejected at t0+2.
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    chk("fs_busy_t0", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("fs_busy_t1", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("fs_busy_t2", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    chk("fs_outs", {26'd0, outs()}, {26'd0, 6'b101101});

    // Back-to-back frames, second start immediately after the first stop period.
    send_frame("b2b_a", 5'b00000, 1'b0, 1'b1, 6'b000000, 1'b1);
    send_frame("b2b_b", 5'b11111, 1'b1, 1'b1, 6'b111111, 1'b1);
    rx = 1'b1;
    repeat (3) @(negedge clk);

    // Reset sampled at t0+14 mid-frame.
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_outs", {26'd0, outs()}, 32'd0);
    chk("midrst_flags", {29'd0, valid, framing_err, busy}, 32'd0);
    rst = 1'b0;
    rx  = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_idle", {31'd0, busy}, 32'd0);
    send_frame("after_rst", 5'b01010, 1'b0, 1'b1, 6'b001010, 1'b1);
    rx = 1'b1;
    repeat (3) @(negedge clk);

    chk("valid_pulses", n_valid, 32'd4);
    chk("ferr_pulses", n_ferr, 32'd1);
    chk("never_both", n_both, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
